// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch slice: FSM states, buffered fetch entry, PC helper.
package fetch_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Word-addressed increment; all-ones wraps to zero.
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory port, redirect/halt control and decode handshake.
interface fetch_if;
  import fetch_pkg::*;

  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              halted;

  // Environment side: memory, branch unit and decode.
  modport master (
    output imem_rdata, redirect_valid, redirect_pc, halt, inst_ready,
    input  imem_addr, inst_valid, inst_data, inst_pc, halted
  );

  // Fetch controller side.
  modport slave (
    input  imem_rdata, redirect_valid, redirect_pc, halt, inst_ready,
    output imem_addr, inst_valid, inst_data, inst_pc, halted
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries; flush drops everything, push is ignored when full.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t wdata_i,
  output fetch_entry_t rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t         mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic                 do_push;
  logic                 do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives instruction memory and buffers words for decode,
// with redirect (flush + new PC) and halt control.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  fetch_if.slave bus
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              halted_q, halted_d;
  logic              push_c;
  logic              flush_c;
  logic              pop_c;
  logic              fifo_full;
  logic              fifo_empty;
  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;

  assign push_entry = '{pc: pc_q, inst: bus.imem_rdata};
  assign pop_c      = ~fifo_empty & bus.inst_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  // Redirect beats halt; fetch only when the buffer had room at the start of the cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push_c  = 1'b0;
    flush_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = RUN;
      end
      RUN: begin
        if (bus.redirect_valid) begin
          flush_c = 1'b1;
          pc_d    = bus.redirect_pc;
        end else if (bus.halt) begin
          state_d = HALTED;
        end else if (!fifo_full) begin
          push_c = 1'b1;
          pc_d   = pc_inc(pc_q);
        end
      end
      HALTED: begin
        if (bus.redirect_valid) begin
          flush_c = 1'b1;
          pc_d    = bus.redirect_pc;
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    halted_d = (state_d == HALTED);
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .flush_i (flush_c),
    .wdata_i (push_entry),
    .rdata_o (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.imem_addr  = pc_q;
  assign bus.inst_valid = ~fifo_empty;
  assign bus.inst_data  = head_entry.inst;
  assign bus.inst_pc    = head_entry.pc;
  assign bus.halted     = halted_q;

endmodule
